// File: rtl/bitu_grp_if.sv
// -----------------------------------------------------------------------------
// bitu_grp_if
// Request/response bundle for the GRP bit-manipulation front end.
//   req0_* / req1_* : two issue ports (valid/ready, 32-bit data and mask, tag)
//   rsp_*           : result port (valid/ready, 32-bit result, requester id, tag)
// Modports:
//   master : the issue/writeback side (drives requests, consumes results)
//   slave  : the controller (accepts requests, produces results)
// -----------------------------------------------------------------------------
interface bitu_grp_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_data;
  logic [31:0]      req0_mask;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_data;
  logic [31:0]      req1_mask;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req0_valid, req0_data, req0_mask, req0_tag,
    input  req0_ready,
    output req1_valid, req1_data, req1_mask, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_mask, req0_tag,
    output req0_ready,
    input  req1_valid, req1_data, req1_mask, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/bitu_grp_ctrl.sv
// -----------------------------------------------------------------------------
// bitu_grp_ctrl
// Two-requester front end and two-stage pipeline for the 32-bit GROUP (GRP)
// bit-manipulation unit. Round-robin arbitration loads stage S1; the
// combinational GRP datapath sits between S1 and S2; S2 drives the response.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous kill of both pipeline stages
//   bus   : bitu_grp_if.slave (two request ports + response port)
//   busy  : S1 or S2 holds a valid entry
//   cnt0  : completions for requester 0 (zero unless the counter option is on)
//   cnt1  : completions for requester 1 (zero unless the counter option is on)
//
// Build option:
//   BITU_GRP_CTRL_PERF_EN : adds saturating per-requester completion counters.
//                           Undefined, cnt0/cnt1 are constant zero.
// -----------------------------------------------------------------------------
module bitu_grp_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  bitu_grp_if.slave        bus,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // GRP: mask=1 bits gather at the LSB end, mask=0 bits follow them upward,
  // both groups keeping ascending order. The mask=0 group starts right above
  // the last mask=1 bit, so all-zero and all-one masks both give identity.
  function automatic logic [31:0] grp_fn(input logic [31:0] data,
                                         input logic [31:0] mask);
    logic [31:0] res;
    logic [5:0]  pos;
    res = '0;
    pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        res[pos[4:0]] = data[i];
        pos           = pos + 6'd1;
      end
    end
    for (int i = 0; i < 32; i++) begin
      if (!mask[i]) begin
        res[pos[4:0]] = data[i];
        pos           = pos + 6'd1;
      end
    end
    return res;
  endfunction

  logic             s1_valid_reg, s1_valid_next;
  logic [31:0]      s1_data_reg, s1_data_next;
  logic [31:0]      s1_mask_reg, s1_mask_next;
  logic             s1_id_reg, s1_id_next;
  logic [TAG_W-1:0] s1_tag_reg, s1_tag_next;

  logic             s2_valid_reg, s2_valid_next;
  logic [31:0]      s2_result_reg, s2_result_next;
  logic             s2_id_reg, s2_id_next;
  logic [TAG_W-1:0] s2_tag_reg, s2_tag_next;

  // rr_reg names the requester that wins when both are valid.
  logic             rr_reg, rr_next;

  logic             s1_adv;
  logic             can_accept;
  logic             grant_id;
  logic             accept;

  // S2 only holds when it has a result the consumer is not taking.
  assign s1_adv     = ~(s2_valid_reg & ~bus.rsp_ready);
  assign can_accept = (~s1_valid_reg | s1_adv) & ~flush;
  // A lone valid requester wins outright; only a tie consults rr_reg.
  assign grant_id   = (bus.req0_valid & bus.req1_valid) ? rr_reg : bus.req1_valid;

  assign bus.req0_ready = can_accept & bus.req0_valid & ~grant_id;
  assign bus.req1_ready = can_accept & bus.req1_valid &  grant_id;
  assign accept         = bus.req0_ready | bus.req1_ready;

  always_comb begin
    s1_valid_next  = s1_valid_reg;
    s1_data_next   = s1_data_reg;
    s1_mask_next   = s1_mask_reg;
    s1_id_next     = s1_id_reg;
    s1_tag_next    = s1_tag_reg;
    s2_valid_next  = s2_valid_reg;
    s2_result_next = s2_result_reg;
    s2_id_next     = s2_id_reg;
    s2_tag_next    = s2_tag_reg;
    rr_next        = rr_reg;

    if (accept) begin
      rr_next = ~grant_id;
    end

    if (flush) begin
      s1_valid_next = 1'b0;
    end else if (accept) begin
      s1_valid_next = 1'b1;
      s1_data_next  = grant_id ? bus.req1_data : bus.req0_data;
      s1_mask_next  = grant_id ? bus.req1_mask : bus.req0_mask;
      s1_id_next    = grant_id;
      s1_tag_next   = grant_id ? bus.req1_tag  : bus.req0_tag;
    end else if (s1_adv) begin
      s1_valid_next = 1'b0;
    end

    if (flush) begin
      s2_valid_next = 1'b0;
    end else if (s1_adv) begin
      s2_valid_next = s1_valid_reg;
      // Payload only moves with a real entry, so an idle slot keeps the last result.
      if (s1_valid_reg) begin
        s2_result_next = grp_fn(s1_data_reg, s1_mask_reg);
        s2_id_next     = s1_id_reg;
        s2_tag_next    = s1_tag_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_mask_reg   <= '0;
      s1_id_reg     <= 1'b0;
      s1_tag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_id_reg     <= 1'b0;
      s2_tag_reg    <= '0;
      rr_reg        <= 1'b0;
    end else begin
      s1_valid_reg  <= s1_valid_next;
      s1_data_reg   <= s1_data_next;
      s1_mask_reg   <= s1_mask_next;
      s1_id_reg     <= s1_id_next;
      s1_tag_reg    <= s1_tag_next;
      s2_valid_reg  <= s2_valid_next;
      s2_result_reg <= s2_result_next;
      s2_id_reg     <= s2_id_next;
      s2_tag_reg    <= s2_tag_next;
      rr_reg        <= rr_next;
    end
  end

  assign bus.rsp_valid = s2_valid_reg;
  assign bus.rsp_data  = s2_result_reg;
  assign bus.rsp_id    = s2_id_reg;
  assign bus.rsp_tag   = s2_tag_reg;
  assign busy          = s1_valid_reg | s2_valid_reg;

`ifdef BITU_GRP_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg [2];
  logic             rsp_fire;

  // A handshake in a flush cycle still counts: the result left the unit.
  assign rsp_fire = s2_valid_reg & bus.rsp_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (rsp_fire && (s2_id_reg == 1'(gi)) && (cnt_reg[gi] != '1)) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
      end
    end
  end

  assign cnt0 = cnt_reg[0];
  assign cnt1 = cnt_reg[1];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_bitu_grp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitu_grp_ctrl
// Directed bench for bitu_grp_ctrl: a table of single GRP requests with
// hand-computed results, then hand-written sequences for contention,
// backpressure, flush, asynchronous reset and the completion counters.
// -----------------------------------------------------------------------------
module tb_bitu_grp_ctrl;
  localparam int TAG_W = 4;
`ifdef BITU_GRP_CTRL_PERF_EN
  localparam int CNT_W = 2;
  localparam bit PERF  = 1'b1;
`else
  localparam int CNT_W = 16;
  localparam bit PERF  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  always #5 clk = ~clk;

  bitu_grp_if #(.TAG_W(TAG_W)) dut_if ();

  bitu_grp_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (dut_if.slave),
    .busy  (busy),
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  typedef struct {
    bit               id;
    logic [31:0]      data;
    logic [31:0]      mask;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  typedef struct {
    bit               id;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } exp_t;

  vec_t        vecs [8];
  vec_t        bp   [3];
  exp_t        exp_q [$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc_cnt = 0;
  int          hs0 = 0;
  int          hs1 = 0;
  int          rule_viol = 0;
  bit          lat_check_en = 1'b1;
  bit          hs_seen;
  logic [31:0] hs_id;
  logic [31:0] hs_tag;
  logic [31:0] cur_exp0;
  logic [31:0] cur_exp1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int hs);
    int max_v;
    max_v = (1 << CNT_W) - 1;
    if (!PERF) return 32'd0;
    return (hs > max_v) ? 32'(max_v) : 32'(hs);
  endfunction

  task automatic drive(input int port, input bit v, input logic [31:0] d, input logic [31:0] m,
                       input logic [TAG_W-1:0] t, input logic [31:0] e);
    if (port == 0) begin
      dut_if.req0_valid = v; dut_if.req0_data = d; dut_if.req0_mask = m; dut_if.req0_tag = t;
      cur_exp0 = e;
    end else begin
      dut_if.req1_valid = v; dut_if.req1_data = d; dut_if.req1_mask = m; dut_if.req1_tag = t;
      cur_exp1 = e;
    end
  endtask

  function automatic bit fire(input int port);
    if (port == 0) return dut_if.req0_valid && dut_if.req0_ready;
    return dut_if.req1_valid && dut_if.req1_ready;
  endfunction

  // Called once per cycle after inputs settle: scores a response handshake
  // and records any request accepted at the coming edge.
  task automatic sample();
    exp_t e;
    hs_seen = 1'b0;
    if ((dut_if.req0_ready && !dut_if.req0_valid) || (dut_if.req1_ready && !dut_if.req1_valid) ||
        (dut_if.req0_ready && dut_if.req1_ready))
      rule_viol++;
    if (dut_if.rsp_valid && dut_if.rsp_ready) begin
      hs_seen = 1'b1;
      hs_id   = 32'(dut_if.rsp_id);
      hs_tag  = 32'(dut_if.rsp_tag);
      if (dut_if.rsp_id) hs1++; else hs0++;
      chk("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", dut_if.rsp_data, e.data);
        chk("rsp_id", 32'(dut_if.rsp_id), 32'(e.id));
        chk("rsp_tag", 32'(dut_if.rsp_tag), 32'(e.tag));
        if (lat_check_en) chk("rsp_latency", 32'(cyc_cnt - e.acc_cyc), 32'd2);
      end
    end
    if (fire(0)) exp_q.push_back('{id: 1'b0, data: cur_exp0, tag: dut_if.req0_tag, acc_cyc: cyc_cnt});
    if (fire(1)) exp_q.push_back('{id: 1'b1, data: cur_exp1, tag: dut_if.req1_tag, acc_cyc: cyc_cnt});
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk); #1; sample();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_two(input int port, input logic [TAG_W-1:0] tag0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      dut_if.rsp_ready = 1'b0;
      drive(port, 1'b1, 32'h0000FFFF, 32'h55555555, tag0 + TAG_W'(c), 32'h00FF00FF);
      #1; sample();
    end
    @(negedge clk);
    drive(port, 1'b0, 32'h0, 32'h0, '0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, n1, nb, k, first_c, last_c;
    bit  acc;
    logic [31:0] cap_data, cap_tag, cap_id;

    vecs[0] = '{id: 1'b0, data: 32'h0000FFFF, mask: 32'h55555555, tag: 4'h3, exp: 32'h00FF00FF};
    vecs[1] = '{id: 1'b0, data: 32'hDEADBEEF, mask: 32'h00000000, tag: 4'h4, exp: 32'hDEADBEEF};
    vecs[2] = '{id: 1'b1, data: 32'hDEADBEEF, mask: 32'hFFFFFFFF, tag: 4'h6, exp: 32'hDEADBEEF};
    vecs[3] = '{id: 1'b1, data: 32'h80000001, mask: 32'h80000000, tag: 4'h5, exp: 32'h00000003};
    vecs[4] = '{id: 1'b1, data: 32'h0000000F, mask: 32'hF0000000, tag: 4'hA, exp: 32'h000000F0};
    vecs[5] = '{id: 1'b0, data: 32'hFFFF0000, mask: 32'hFFFF0000, tag: 4'h7, exp: 32'h0000FFFF};
    vecs[6] = '{id: 1'b0, data: 32'hAAAAAAAA, mask: 32'hAAAAAAAA, tag: 4'h1, exp: 32'h0000FFFF};
    vecs[7] = '{id: 1'b1, data: 32'h12345678, mask: 32'h000000F0, tag: 4'hF, exp: 32'h12345687};
    bp[0]   = '{id: 1'b0, data: 32'h0000FFFF, mask: 32'h55555555, tag: 4'h8, exp: 32'h00FF00FF};
    bp[1]   = '{id: 1'b0, data: 32'h80000001, mask: 32'h80000000, tag: 4'h9, exp: 32'h00000003};
    bp[2]   = '{id: 1'b0, data: 32'h0000000F, mask: 32'hF0000000, tag: 4'hA, exp: 32'h000000F0};

    drive(0, 1'b0, 32'h0, 32'h0, '0, 32'h0);
    drive(1, 1'b0, 32'h0, 32'h0, '0, 32'h0);
    dut_if.rsp_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("reset_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
    chk("reset_rsp_data", dut_if.rsp_data, 32'd0);
    chk("reset_rsp_id", 32'(dut_if.rsp_id), 32'd0);
    chk("reset_rsp_tag", 32'(dut_if.rsp_tag), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt0", 32'(cnt0), 32'd0);
    chk("reset_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of isolated requests, full-rate consumer
    foreach (vecs[v]) begin
      @(negedge clk);
      drive(int'(vecs[v].id), 1'b1, vecs[v].data, vecs[v].mask, vecs[v].tag, vecs[v].exp);
      acc = 1'b0;
      for (int w = 0; w < 10 && !acc; w++) begin
        if (w > 0) @(negedge clk);
        #1; acc = fire(int'(vecs[v].id)); sample();
      end
      chk("vec_accept", 32'(acc), 32'd1);
      @(negedge clk);
      drive(int'(vecs[v].id), 1'b0, 32'h0, 32'h0, '0, 32'h0);
      #1; sample();
      wait_drain("vec_drain");
      $display("vec %0d: id=%0d data=0x%08h mask=0x%08h tag=%0d exp=0x%08h", v, vecs[v].id,
               vecs[v].data, vecs[v].mask, vecs[v].tag, vecs[v].exp);
    end

    // Contention: both requesters valid, six requests each
    n0 = 0; n1 = 0; k = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      @(negedge clk);
      drive(0, n0 < 6, 32'h00000000 + 32'(n0), 32'h0, TAG_W'(n0), 32'h00000000 + 32'(n0));
      drive(1, n1 < 6, 32'h00000100 + 32'(n1), 32'h0, TAG_W'(n1), 32'h00000100 + 32'(n1));
      #1;
      if (fire(0)) n0++;
      if (fire(1)) n1++;
      sample();
      if (hs_seen) begin
        chk("cont_rsp_id", hs_id, 32'(k % 2));
        chk("cont_rsp_tag", hs_tag, 32'(k / 2));
        if (k == 0) first_c = cyc_cnt;
        last_c = cyc_cnt;
        $display("contention rsp %0d: id=%0d tag=%0d", k, hs_id, hs_tag);
        k++;
      end
    end
    chk("cont_rsp_count", 32'(k), 32'd12);
    chk("cont_back_to_back", 32'(last_c - first_c), 32'd11);

    // Backpressure: consumer stalled for five cycles, three requests queued
    lat_check_en = 1'b0;
    nb = 0; cap_data = '0; cap_tag = '0; cap_id = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dut_if.rsp_ready = 1'b0;
      if (nb < 3) drive(0, 1'b1, bp[nb].data, bp[nb].mask, bp[nb].tag, bp[nb].exp);
      else        drive(0, 1'b0, 32'h0, 32'h0, '0, 32'h0);
      #1;
      if (fire(0)) nb++;
      sample();
      if (c == 2) begin
        chk("bp_rsp_valid", 32'(dut_if.rsp_valid), 32'd1);
        cap_data = dut_if.rsp_data; cap_tag = 32'(dut_if.rsp_tag); cap_id = 32'(dut_if.rsp_id);
      end
      if (c == 4) begin
        chk("bp_hold_valid", 32'(dut_if.rsp_valid), 32'd1);
        chk("bp_hold_data", dut_if.rsp_data, cap_data);
        chk("bp_hold_tag", 32'(dut_if.rsp_tag), cap_tag);
        chk("bp_hold_id", 32'(dut_if.rsp_id), cap_id);
        chk("bp_req0_ready", 32'(dut_if.req0_ready), 32'd0);
      end
    end
    chk("bp_accepts", 32'(nb), 32'd2);
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clk);
      dut_if.rsp_ready = 1'b1;
      if (nb < 3) drive(0, 1'b1, bp[nb].data, bp[nb].mask, bp[nb].tag, bp[nb].exp);
      else        drive(0, 1'b0, 32'h0, 32'h0, '0, 32'h0);
      #1;
      if (fire(0)) nb++;
      sample();
      if (hs_seen) begin
        $display("backpressure drain %0d: tag=%0d", k, hs_tag);
        k++;
      end
    end
    chk("bp_drain_count", 32'(k), 32'd3);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with both stages occupied
    fill_two(1, 4'h1);
    @(negedge clk);
    flush = 1'b1;
    drive(1, 1'b1, 32'h0F0F0F0F, 32'h0, 4'h3, 32'h0F0F0F0F);
    #1;
    chk("flush_busy_before", 32'(busy), 32'd1);
    chk("flush_req1_ready", 32'(dut_if.req1_ready), 32'd0);
    sample();
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    dut_if.rsp_ready = 1'b1;
    lat_check_en = 1'b1;
    #1;
    chk("flush_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_next_accept", 32'(fire(1)), 32'd1);
    sample();
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 32'h0, '0, 32'h0);
    #1; sample();
    wait_drain("flush_follow_drain");
    $display("flush: follow-up request drained");

    chk("perf_cnt0_mid", 32'(cnt0), exp_cnt(hs0));
    chk("perf_cnt1_mid", 32'(cnt1), exp_cnt(hs1));

    // Asynchronous reset in the middle of a stream
    fill_two(1, 4'hC);
    #2;
    chk("pre_rst_rsp_valid", 32'(dut_if.rsp_valid), 32'd1);
    chk("pre_rst_rsp_id", 32'(dut_if.rsp_id), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
    chk("async_rst_rsp_data", dut_if.rsp_data, 32'd0);
    chk("async_rst_rsp_id", 32'(dut_if.rsp_id), 32'd0);
    chk("async_rst_rsp_tag", 32'(dut_if.rsp_tag), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_cnt0", 32'(cnt0), 32'd0);
    chk("async_rst_cnt1", 32'(cnt1), 32'd0);
    exp_q.delete();
    hs0 = 0; hs1 = 0;
    @(negedge clk);
    rst = 1'b0;
    dut_if.rsp_ready = 1'b1;
    $display("reset: asserted mid-stream and released");

    // After reset requester 0 has priority; then five requester-1 completions
    @(negedge clk);
    drive(0, 1'b1, 32'h1, 32'h0, 4'h0, 32'h1);
    drive(1, 1'b1, 32'h2, 32'h0, 4'h0, 32'h2);
    #1;
    chk("rst_prio_req0_ready", 32'(dut_if.req0_ready), 32'd1);
    chk("rst_prio_req1_ready", 32'(dut_if.req1_ready), 32'd0);
    drive(0, 1'b0, 32'h0, 32'h0, '0, 32'h0);
    #1;
    n1 = 0;
    if (fire(1)) n1++;
    sample();
    for (int c = 0; c < 20 && n1 < 5; c++) begin
      @(negedge clk);
      drive(1, 1'b1, 32'h2 + 32'(n1), 32'h0, TAG_W'(n1), 32'h2 + 32'(n1));
      #1;
      if (fire(1)) n1++;
      sample();
    end
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 32'h0, '0, 32'h0);
    #1; sample();
    wait_drain("perf_drain");
    chk("perf_hs1", 32'(hs1), 32'd5);
    chk("perf_cnt0", 32'(cnt0), exp_cnt(hs0));
    chk("perf_cnt1", 32'(cnt1), exp_cnt(hs1));
    $display("perf: cnt0=%0d cnt1=%0d after %0d/%0d completions", cnt0, cnt1, hs0, hs1);

    chk("ready_rules", 32'(rule_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
